// File: rtl/dual_port_block_ram_if.sv
// One port of the dual-port block RAM: access request plus returned read data.
// Latency: none (wires only).
// Backpressure: none; a port accepts an access on every enabled clock edge.
interface dual_port_block_ram_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 10,
  parameter int NB    = 2
);
  logic             en;
  logic [NB-1:0]    we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             valid;

  // Requester drives the access, RAM returns data and valid.
  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/dual_port_block_ram.sv
// True dual-port byte-writable block RAM on one clock; optional macro BRAM_COLLISION_FLAG_EN adds a collision strobe.
// Latency: READ_LATENCY (1 or 2) cycles from access edge to dout/valid.
// Backpressure: none; every enabled access is taken, valid marks each returned read.
module dual_port_block_ram #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 1024,
  parameter int BYTE_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input logic clk,
  input logic rst,
  dual_port_block_ram_if.slave a,
  dual_port_block_ram_if.slave b
`ifdef BRAM_COLLISION_FLAG_EN
  ,
  output logic collision
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / BYTE_W;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dual_port_block_ram: READ_LATENCY must be 1 or 2");
  end
  if (WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("dual_port_block_ram: WIDTH must be a multiple of BYTE_W");
  end

  // Contents start at zero and survive rst; only the read path is reset.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic             a_ok, b_ok, a_rd, b_rd;
  logic [WIDTH-1:0] a_old, b_old, a_word, b_word;
  logic [WIDTH-1:0] a_s1_dat, b_s1_dat;
  logic             a_s1_vld, b_s1_vld;

  // Overlay the written lanes onto the stored word.
  function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] old_w,
                                                  input logic [NB-1:0]    we,
                                                  input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] w;
    w = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) w[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    end
    return w;
  endfunction

  // Out-of-range addresses (non power-of-2 DEPTH) drop writes and read as zero.
  assign a_ok = ({1'b0, a.addr} < DEPTH_L);
  assign b_ok = ({1'b0, b.addr} < DEPTH_L);

  // NO_CHANGE suppresses the read on any write; other modes always read.
  assign a_rd = a.en && ((a.we == '0) || (WRITE_MODE != 2));
  assign b_rd = b.en && ((b.we == '0) || (WRITE_MODE != 2));

  // Read word: the pre-edge contents, merged with own write data in WRITE_FIRST.
  // The other port's write is never visible here, so cross-port reads see old data.
  always_comb begin
    a_old  = '0;
    b_old  = '0;
    if (a_ok) a_old = mem[a.addr];
    if (b_ok) b_old = mem[b.addr];
    a_word = a_old;
    b_word = b_old;
    if (WRITE_MODE == 1 && a_ok) a_word = merge_word(a_old, a.we, a.din);
    if (WRITE_MODE == 1 && b_ok) b_word = merge_word(b_old, b.we, b.din);
  end

  // Array write; port A is applied last so it owns any lane both ports write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (b.en && b.we[i] && b_ok) mem[b.addr][i*BYTE_W +: BYTE_W] <= b.din[i*BYTE_W +: BYTE_W];
      if (a.en && a.we[i] && a_ok) mem[a.addr][i*BYTE_W +: BYTE_W] <= a.din[i*BYTE_W +: BYTE_W];
    end
  end

  // RAM output register: loads only on a read, so dout holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1_dat <= '0;
      a_s1_vld <= 1'b0;
      b_s1_dat <= '0;
      b_s1_vld <= 1'b0;
    end else begin
      a_s1_vld <= a_rd;
      b_s1_vld <= b_rd;
      if (a_rd) a_s1_dat <= a_word;
      if (b_rd) b_s1_dat <= b_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] a_s2_dat, b_s2_dat;
    logic             a_s2_vld, b_s2_vld;

    // Output pipeline stage: data loads only from a valid stage-1 word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_s2_dat <= '0;
        a_s2_vld <= 1'b0;
        b_s2_dat <= '0;
        b_s2_vld <= 1'b0;
      end else begin
        a_s2_vld <= a_s1_vld;
        b_s2_vld <= b_s1_vld;
        if (a_s1_vld) a_s2_dat <= a_s1_dat;
        if (b_s1_vld) b_s2_dat <= b_s1_dat;
      end
    end

    assign a.dout  = a_s2_dat;
    assign a.valid = a_s2_vld;
    assign b.dout  = b_s2_dat;
    assign b.valid = b_s2_vld;
  end else begin : g_lat1
    assign a.dout  = a_s1_dat;
    assign a.valid = a_s1_vld;
    assign b.dout  = b_s1_dat;
    assign b.valid = b_s1_vld;
  end

`ifdef BRAM_COLLISION_FLAG_EN
  // One-cycle flag for any same-address access pair where either side writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision <= 1'b0;
    else     collision <= a.en & b.en & (a.addr == b.addr) & ((|a.we) | (|b.we));
  end
`endif

endmodule

// File: doc/dual_port_block_ram.md
Name: dual_port_block_ram

Overview:
Single-clock true dual-port block RAM that generalises the single-port block RAM.
- Two independent read/write ports A and B, both on clk.
- Byte-granular write enables, selectable same-port read-during-write mode, selectable read latency (1 or 2) and per-port read-valid strobes.
- Shared-buffer primitive for packet buffers and coefficient tables, where one engine writes while another reads.

Parameters:
WIDTH, 16, data width in bits; must be an integer multiple of BYTE_W.
DEPTH, 1024, number of words; address width AW = $clog2(DEPTH).
BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W lanes.
READ_LATENCY, 1, 1 = RAM output register only; 2 = additional output pipeline register. Other values are illegal and trigger an elaboration $error.
WRITE_MODE, 0, same-port read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
a_en  input  1  port A access enable
a_we  input  NB  port A byte write enables, lane i = bits [i*BYTE_W +: BYTE_W]
a_addr  input  AW  port A address
a_din  input  WIDTH  port A write data
a_dout  output  WIDTH  port A read data
a_valid  output  1  port A read data valid
b_en, b_we, b_addr, b_din, b_dout, b_valid  same as port A, for port B

Behaviour:
- Memory array is initialised to all zeros at configuration. rst does NOT clear the memory array.
- rst asserted clears a_dout, b_dout, both pipeline stages and a_valid, b_valid to 0, immediately (asynchronously).
- Any access issued in the cycle rst deasserts is honoured normally.

Access rules, per port P at each rising edge with P_en=1:
- Each lane with P_we[i]=1 writes P_din lane i to mem[P_addr].
- A read occurs when P_we==0, or when any write enable is set and WRITE_MODE!=2.
- P_en=0: no read, no write, P_dout holds its value, and P_valid produces a 0 after the configured latency.

Latency:
- READ_LATENCY=1: data on P_dout and P_valid=1 in the cycle after the access edge.
- READ_LATENCY=2: one cycle later. Stage-2 register holds when its input is not valid, so P_dout always shows the last valid read.

Same-port read-during-write:
- READ_FIRST: P_dout = old word.
- WRITE_FIRST: P_dout = merged new word (written lanes new, unwritten lanes old).
- NO_CHANGE: P_dout holds its previous value and P_valid=0 for that access.

Cross-port behaviour:
- Port reading an address the other port writes in the same cycle returns the old word, whatever WRITE_MODE is set to.
- Both ports write the same address in the same cycle: port A wins for every lane where a_we[i]=1. Port B's lanes are written only where a_we[i]=0.
- Both ports read the same address: both return identical data.

Addressing:
- Addresses >= DEPTH (non-power-of-2 DEPTH) are ignored. Writes are dropped; reads return 0 with P_valid=1.

Optional Feature:
Macro BRAM_COLLISION_FLAG_EN.
- Defined: adds output port `collision` (1 bit, reset 0). It is registered high for exactly one cycle after any edge where a_en & b_en & (a_addr==b_addr) & (|a_we | |b_we).
- Not defined: port and logic are absent; collision resolution is unchanged.

Test Plan:
- Reset: pulse rst mid-read with READ_LATENCY=2 -> a_dout, b_dout, a_valid, b_valid go 0 immediately and no stale valid emerges afterwards. Reading addr 5 after reset still returns the value written before reset.
- Byte write: write 16'hAAAA to addr 3, then a_we=2'b01 with 16'h1234 -> read of addr 3 returns 16'hAA34 one cycle later (latency 1), with a_valid high for one cycle.
- Read-during-write: mem[7]=16'h0001, port A writes 16'h00FF to addr 7 with a read. READ_FIRST -> 16'h0001; WRITE_FIRST -> 16'h00FF; NO_CHANGE -> a_dout unchanged, a_valid=0.
- Collision: A writes 16'h1111 (we=11) and B writes 16'h2222 (we=01) to addr 9 in the same cycle -> mem[9]=16'h1111. With the macro defined, collision=1 for one cycle.
- Cross-port: A writes 16'hBEEF to addr 12 while B reads addr 12 (old 0) -> b_dout=16'h0000. B reads addr 12 again next cycle -> 16'hBEEF.
- Back-to-back streaming: READ_LATENCY=2, B reads addrs 0..15 consecutively -> b_valid high 16 consecutive cycles starting 2 cycles after the first read, data in address order.
